// File: rtl/branch_ctrl.sv
// branch_ctrl: EX-stage redirect/flush controller (IDLE -> REDIRECT -> DRAIN).
// Define BRANCH_STATS_EN to build the br_count/taken_count statistics counters.
module branch_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [4:0]  ex_buop,
    input  logic        ex_take,
    input  logic [31:0] ex_target,
    input  logic        stall,
    input  logic        stats_clr,
    output logic        pc_sel,
    output logic [31:0] pc_target,
    output logic        flush_if,
    output logic        flush_id,
    output logic        misalign_err,
    output logic        busy,
    output logic [15:0] br_count,
    output logic [15:0] taken_count
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REDIRECT = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [31:0] r_pc_target;
    logic        r_misalign;
    logic        w_branch;
    logic        w_accept;
    logic        w_redirect;
    logic        w_misalign;
    logic        w_unused;

    assign w_branch   = ex_valid && (ex_buop[4:3] != 2'b00);
    assign w_accept   = w_branch && !stall && (r_state == S_IDLE);
    assign w_redirect = w_accept && ex_take && (ex_target[1:0] == 2'b00);
    assign w_misalign = w_accept && ex_take && (ex_target[1:0] != 2'b00);

    always_comb
        w_next = (r_state == S_IDLE)     ? (w_redirect ? S_REDIRECT : S_IDLE) :
                 (r_state == S_REDIRECT) ? (stall ? S_REDIRECT : S_DRAIN) :
                                           S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc_target <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_misalign <= w_misalign;
            if (w_redirect)
                r_pc_target <= ex_target;
        end
    end

    // All control outputs decode straight from flops so reset clears them at once
    assign pc_sel       = (r_state == S_REDIRECT);
    assign flush_if     = (r_state == S_REDIRECT);
    assign flush_id     = (r_state == S_REDIRECT) || (r_state == S_DRAIN);
    assign busy         = (r_state != S_IDLE);
    assign misalign_err = r_misalign;
    assign pc_target    = r_pc_target;

`ifdef BRANCH_STATS_EN
    logic [15:0] r_br_count;
    logic [15:0] r_taken_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else if (stats_clr) begin
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else begin
            if (w_accept && (r_br_count != 16'hFFFF))
                r_br_count <= r_br_count + 16'd1;
            if (w_redirect && (r_taken_count != 16'hFFFF))
                r_taken_count <= r_taken_count + 16'd1;
        end
    end

    assign br_count    = r_br_count;
    assign taken_count = r_taken_count;
    assign w_unused    = ^ex_buop[2:0];
`else
    assign br_count    = '0;
    assign taken_count = '0;
    assign w_unused    = ^{ex_buop[2:0], stats_clr};
`endif
endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have the port clk, input, 1 bit: the single clock, rising edge.
REQ-002 SHALL have the port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have the port ex_valid, input, 1 bit: the EX stage holds a valid instruction.
REQ-004 SHALL have the port ex_buop, input, 5 bits: the branch-unit operation code of the EX instruction (00xxx = no branch, 01xxx = conditional, 1xxxx = jump).
REQ-005 SHALL have the port ex_take, input, 1 bit: the branch-unit taken decision for the EX instruction.
REQ-006 SHALL have the port ex_target, input, 32 bits: the computed branch/jump target address.
REQ-007 SHALL have the port stall, input, 1 bit: a pipeline stall from the hazard logic.
REQ-008 SHALL have the port stats_clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-009 SHALL have the port pc_sel, output, 1 bit: when high, the PC loads pc_target.
REQ-010 SHALL have the port pc_target, output, 32 bits: the registered redirect address.
REQ-011 SHALL have the port flush_if, output, 1 bit: kill the IF/ID register contents.
REQ-012 SHALL have the port flush_id, output, 1 bit: kill the ID/EX register contents.
REQ-013 SHALL have the port misalign_err, output, 1 bit: one-cycle pulse for a misaligned target.
REQ-014 SHALL have the port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 SHALL have the port br_count, output, 16 bits: the count of branch-class instructions.
REQ-016 SHALL have the port taken_count, output, 16 bits: the count of redirects.

Function
REQ-017 SHALL treat an instruction as branch-class when ex_valid=1 and ex_buop[4:3]!=2'b00.
REQ-018 SHALL raise a redirect request when the instruction is branch-class, ex_take=1, ex_target[1:0]==2'b00, stall=0 and the state is IDLE.
REQ-019 SHALL implement three states, IDLE, REDIRECT and DRAIN, with IDLE as the reset state.
REQ-020 SHALL, on a redirect request in IDLE, register ex_target into pc_target and move to REDIRECT at the next edge (one-cycle latency).
REQ-021 SHALL, in REDIRECT, drive pc_sel=1, flush_if=1 and flush_id=1.
REQ-022 SHALL remain in REDIRECT with all outputs held while stall=1, and move to DRAIN at the first edge with stall=0.
REQ-023 SHALL, in DRAIN, drive flush_id=1 only, and move to IDLE at the next edge regardless of stall.
REQ-024 SHALL ignore ex_valid, ex_take and ex_buop in REDIRECT and DRAIN, because those instructions are being flushed.
REQ-025 SHALL, for a branch-class instruction with ex_take=1, ex_target[1:0]!=0, stall=0 in IDLE, pulse misalign_err for exactly one cycle after the edge and stay in IDLE with no redirect.
REQ-026 SHALL, for a not-taken branch (ex_take=0), stay in IDLE with all flush outputs low.
REQ-027 SHALL hold pc_target at its last value outside REDIRECT.
REQ-028 SHALL take no action for ex_buop=00xxx, even when ex_take=1.
REQ-029 SHALL accept back-to-back redirects with a minimum spacing of 3 cycles (IDLE, REDIRECT, DRAIN).

Reset
REQ-030 SHALL, on rst_n low at any time (including mid-REDIRECT or mid-DRAIN), immediately force state=IDLE, pc_sel=0, flush_if=0, flush_id=0, misalign_err=0, busy=0, pc_target=0, br_count=0 and taken_count=0.
REQ-031 SHALL take its first action on the first rising edge after rst_n deasserts.

Configuration
REQ-032 SHALL compile in the statistics counters when the macro BRANCH_STATS_EN is defined.
REQ-033 SHALL, with BRANCH_STATS_EN defined, increment br_count once per branch-class instruction accepted in IDLE with stall=0.
REQ-034 SHALL, with BRANCH_STATS_EN defined, increment taken_count once per entry into REDIRECT.
REQ-035 SHALL, with BRANCH_STATS_EN defined, saturate both counters at 16'hFFFF, and have stats_clr=1 zero both counters, taking priority over any increment in the same cycle.
REQ-036 SHALL, without BRANCH_STATS_EN, keep the port list unchanged, tie br_count and taken_count to 0, ignore stats_clr, and generate no counter flops.

Verification
REQ-037 SHALL verify a taken redirect: ex_buop=01000, ex_take=1, ex_target=0x0000_0100, stall=0 -> next cycle pc_sel=1, flush_if=1, flush_id=1, pc_target=0x100; then flush_id alone for 1 cycle; then busy=0.
REQ-038 SHALL verify a not-taken branch: ex_buop=01100, ex_take=0 -> all flush outputs stay 0; br_count +1 and taken_count unchanged (stats build).
REQ-039 SHALL verify stall in REDIRECT: stall=1 for 3 cycles in REDIRECT -> pc_sel=1 held for 4 cycles total, then DRAIN for 1 cycle.
REQ-040 SHALL verify a misaligned target: ex_buop=10000, ex_take=1, ex_target=0x102 -> misalign_err=1 for 1 cycle, pc_sel stays 0.
REQ-041 SHALL verify reset mid-operation: rst_n=0 during DRAIN -> all outputs 0 immediately, without waiting for a clock edge.
REQ-042 SHALL verify counter saturation: preload taken_count=0xFFFF plus one more redirect -> stays 0xFFFF; stats_clr=1 together with an increment -> 0.
